// File: rtl/seq_divider_16bit_pkg.sv
// rtl/seq_divider_16bit_pkg.sv - shared constants and state encoding for the sequential divider
package seq_divider_16bit_pkg;

    localparam int WIDTH = 16;
    localparam logic [WIDTH-1:0] DIV0_Q = 16'hFFFF;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/seq_divider_16bit_trial_sub.sv
// rtl/seq_divider_16bit_trial_sub.sv - 17-bit carry-lookahead trial subtractor, a + ~b + 1
module div_trial_sub
    import seq_divider_16bit_pkg::*;
(
    output logic [WIDTH:0] diff,
    output logic           borrow,
    input  logic [WIDTH:0] a,
    input  logic [WIDTH:0] b
);

    localparam int W = WIDTH + 1;

    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W:0]   c;

    // Carries from the generate/propagate recurrence, carry-in of 1 for two's complement.
    function automatic logic [W:0] lookahead(input logic [W-1:0] gi, input logic [W-1:0] pi);
        logic [W:0] cc;
        cc[0] = 1'b1;
        for (int i = 0; i < W; i++) begin
            cc[i+1] = gi[i] | (pi[i] & cc[i]);
        end
        return cc;
    endfunction

    always_comb begin
        g      = a & ~b;
        p      = a ^ ~b;
        c      = lookahead(g, p);
        diff   = p ^ c[W-1:0];
        borrow = ~c[W];
    end

endmodule

// File: rtl/seq_divider_16bit.sv
// rtl/seq_divider_16bit.sv - unsigned 16-bit restoring divider with start/busy/done handshake
module seq_divider_16bit
    import seq_divider_16bit_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH:0]   prem;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] dsr_reg;
    logic [CNT_W-1:0] cnt;
    logic             fin;
    logic             dz_reg;

    logic [WIDTH:0]   trial_a;
    logic [WIDTH:0]   trial_diff;
    logic             trial_borrow;

    assign trial_a = {prem[WIDTH-1:0], q_reg[WIDTH-1]};

    div_trial_sub u_sub (
        .diff   (trial_diff),
        .borrow (trial_borrow),
        .a      (trial_a),
        .b      ({1'b0, dsr_reg})
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (fin) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // fin marks a spare cycle after the last iteration so results land one edge
    // later; a zero divisor skips the iterations but keeps the same finishing step.
    always_ff @(posedge clk) begin
        if (rst) begin
            prem        <= '0;
            q_reg       <= '0;
            dsr_reg     <= '0;
            cnt         <= '0;
            fin         <= 1'b0;
            dz_reg      <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        q_reg   <= dividend;
                        dsr_reg <= divisor;
                        prem    <= '0;
                        cnt     <= '0;
                        fin     <= 1'b0;
                        dz_reg  <= (divisor == '0);
                        busy    <= 1'b1;
                    end
                end
                RUN: begin
                    if (fin) begin
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        div_by_zero <= dz_reg;
                        quotient    <= dz_reg ? DIV0_Q : q_reg;
                        remainder   <= dz_reg ? q_reg : prem[WIDTH-1:0];
                    end else if (dz_reg) begin
                        fin <= 1'b1;
                    end else begin
                        prem  <= trial_borrow ? trial_a : trial_diff;
                        q_reg <= {q_reg[WIDTH-2:0], ~trial_borrow};
                        cnt   <= cnt + 1'b1;
                        if (cnt == 4'd15) fin <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider_16bit.sv
// tb/tb_seq_divider_16bit.sv - scoreboard bench for seq_divider_16bit
module tb_seq_divider_16bit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    always #5 clk = ~clk;

    seq_divider_16bit dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    typedef struct packed {
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   n_push = 0;
    int   n_done = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        e.dz = (b == 16'd0);
        e.q  = e.dz ? 16'hFFFF : a / b;
        e.r  = e.dz ? a : a % b;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            n_done++;
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("quotient", {16'd0, quotient}, {16'd0, e.q});
                check("remainder", {16'd0, remainder}, {16'd0, e.r});
                check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dz});
            end
        end
    end

    // Waits for done after the accepting edge; lat counts edges from E, bcnt busy cycles.
    task automatic wait_done(input int from, output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        for (int k = from; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
            if (busy) bcnt++;
        end
        if (lat == 0) check("timeout", 32'd0, 32'd1);
    endtask

    task automatic issue(input logic [15:0] a, input logic [15:0] b, output int lat, output int bcnt);
        int l;
        int bc;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        sb.push_back(model(a, b));
        n_push++;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 16'($urandom);
        divisor  = 16'($urandom);
        wait_done(1, l, bc);
        lat  = l;
        bcnt = bc + (busy ? 0 : 1);
    endtask

    task automatic normal_op(input logic [15:0] a, input logic [15:0] b);
        int lat;
        int bcnt;
        issue(a, b, lat, bcnt);
        check("latency", lat, 32'd17);
        check("busy_cycles", bcnt, 32'd17);
        check("busy_at_done", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        check("done_pulse", {31'd0, done}, 32'd0);
    endtask

    logic [15:0] a_tab [5] = '{16'd100, 16'hFFFF, 16'hFFFF, 16'd3, 16'd0};
    logic [15:0] b_tab [5] = '{16'd7, 16'd1, 16'hFFFF, 16'd10, 16'd5};

    initial begin
        int lat;
        int bcnt;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = 16'd0;
        divisor  = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_quotient", {16'd0, quotient}, 32'd0);
        check("rst_remainder", {16'd0, remainder}, 32'd0);
        check("rst_dz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) normal_op(a_tab[i], b_tab[i]);

        issue(16'd5, 16'd0, lat, bcnt);
        check("dz_latency", lat, 32'd2);
        check("dz_busy_at_done", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        check("dz_done_pulse", {31'd0, done}, 32'd0);
        check("dz_hold", {31'd0, div_by_zero}, 32'd1);
        normal_op(16'd9, 16'd3);

        @(negedge clk);
        dividend = 16'd1000;
        divisor  = 16'd9;
        start    = 1'b1;
        sb.push_back(model(16'd1000, 16'd9));
        n_push++;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        start    = 1'b1;
        dividend = 16'd7;
        divisor  = 16'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(7, lat, bcnt);
        check("ign_latency", lat, 32'd17);
        @(posedge clk);
        #1;
        check("ign_done_low", {31'd0, done}, 32'd0);
        check("ign_hold_q", {16'd0, quotient}, 32'd111);
        check("ign_hold_r", {16'd0, remainder}, 32'd1);
        check("ign_busy", {31'd0, busy}, 32'd0);

        @(negedge clk);
        dividend = 16'd500;
        divisor  = 16'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        check("mid_rst_q", {16'd0, quotient}, 32'd0);
        check("mid_rst_r", {16'd0, remainder}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        normal_op(16'd500, 16'd3);

        repeat (25) @(posedge clk);
        #1;
        check("pending", sb.size(), 32'd0);
        check("done_count", n_done, n_push);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
